// File: rtl/regfile_bypass.sv
// Two-read/one-write register file: 1-cycle registered reads with write-to-read bypass, plus a register dump port.
// The dump streams one word per valid/ready transfer and holds the word while i_dump_ready is low; reads and writes never stall.
module regfile_bypass #(
   parameter int LEN      = 32,
   parameter int NB_REG   = 32,
   parameter int NB_ADDR  = 5,
   parameter int ZERO_REG = 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_enable,
   input  logic               i_RegWrite,
   input  logic [NB_ADDR-1:0] i_read_register_1,
   input  logic [NB_ADDR-1:0] i_read_register_2,
   input  logic [NB_ADDR-1:0] i_write_register,
   input  logic [LEN-1:0]     i_write_data,
   output logic [LEN-1:0]     o_read_data_1,
   output logic [LEN-1:0]     o_read_data_2,
   input  logic               i_dump_start,
   input  logic               i_dump_ready,
   output logic               o_dump_valid,
   output logic [NB_ADDR-1:0] o_dump_addr,
   output logic [LEN-1:0]     o_dump_data,
   output logic               o_dump_busy,
   output logic               o_dump_done
);

   localparam logic [NB_ADDR:0]   REG_CNT  = (NB_ADDR+1)'(NB_REG);
   localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(NB_REG - 1);

   typedef enum logic [1:0] {IDLE, DUMP, DONE} dump_state_t;

   logic [LEN-1:0]     regs [NB_REG];
   dump_state_t        state;
   logic               wr_ok;
   logic [NB_ADDR-1:0] nxt_idx;
   logic [LEN-1:0]     rd_nxt_1;
   logic [LEN-1:0]     rd_nxt_2;

   function automatic logic is_live(input logic [NB_ADDR-1:0] a);
      return ({1'b0, a} < REG_CNT) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   // Stored value only; out-of-range and the hard-wired zero register read as 0.
   function automatic logic [LEN-1:0] stored(input logic [NB_ADDR-1:0] a);
      return is_live(a) ? regs[a] : '0;
   endfunction

   assign wr_ok    = i_RegWrite && is_live(i_write_register);
   assign nxt_idx  = o_dump_addr + 1'b1;
   assign rd_nxt_1 = (wr_ok && (i_write_register == i_read_register_1)) ? i_write_data
                                                                        : stored(i_read_register_1);
   assign rd_nxt_2 = (wr_ok && (i_write_register == i_read_register_2)) ? i_write_data
                                                                        : stored(i_read_register_2);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < NB_REG; i++) regs[i] <= '0;
      end else if (wr_ok) begin
         regs[i_write_register] <= i_write_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_read_data_1 <= '0;
         o_read_data_2 <= '0;
      end else if (i_enable) begin
         o_read_data_1 <= rd_nxt_1;
         o_read_data_2 <= rd_nxt_2;
      end
   end

   // o_dump_addr doubles as the dump index; the next word is latched on the accepting edge.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state        <= IDLE;
         o_dump_addr  <= '0;
         o_dump_data  <= '0;
         o_dump_valid <= 1'b0;
         o_dump_busy  <= 1'b0;
         o_dump_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               o_dump_done <= 1'b0;
               if (i_dump_start) begin
                  state        <= DUMP;
                  o_dump_addr  <= '0;
                  o_dump_data  <= stored('0);
                  o_dump_valid <= 1'b1;
                  o_dump_busy  <= 1'b1;
               end
            end
            DUMP: begin
               if (i_dump_ready) begin
                  if (o_dump_addr == LAST_IDX) begin
                     state        <= DONE;
                     o_dump_valid <= 1'b0;
                     o_dump_busy  <= 1'b0;
                     o_dump_done  <= 1'b1;
                  end else begin
                     o_dump_addr <= nxt_idx;
                     o_dump_data <= stored(nxt_idx);
                  end
               end
            end
            DONE: begin
               o_dump_done <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench for regfile_bypass: directed vectors feed expectation queues; negedge monitors pop and compare.
module tb_regfile_bypass;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_enable = 1'b0;
   logic        i_RegWrite = 1'b0;
   logic [4:0]  i_read_register_1 = '0;
   logic [4:0]  i_read_register_2 = '0;
   logic [4:0]  i_write_register = '0;
   logic [31:0] i_write_data = '0;
   logic [31:0] o_read_data_1;
   logic [31:0] o_read_data_2;
   logic        i_dump_start = 1'b0;
   logic        i_dump_ready = 1'b0;
   logic        o_dump_valid;
   logic [4:0]  o_dump_addr;
   logic [31:0] o_dump_data;
   logic        o_dump_busy;
   logic        o_dump_done;

   always #5 i_clk = ~i_clk;

   regfile_bypass dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_RegWrite(i_RegWrite),
      .i_read_register_1(i_read_register_1), .i_read_register_2(i_read_register_2),
      .i_write_register(i_write_register), .i_write_data(i_write_data),
      .o_read_data_1(o_read_data_1), .o_read_data_2(o_read_data_2),
      .i_dump_start(i_dump_start), .i_dump_ready(i_dump_ready),
      .o_dump_valid(o_dump_valid), .o_dump_addr(o_dump_addr), .o_dump_data(o_dump_data),
      .o_dump_busy(o_dump_busy), .o_dump_done(o_dump_done)
   );

   typedef struct {logic c1; logic [31:0] e1; logic c2; logic [31:0] e2;} rd_ent_t;
   typedef struct {logic [4:0] a; logic [31:0] d;} dmp_ent_t;

   rd_ent_t  rd_q[$];
   dmp_ent_t dq[$];
   rd_ent_t  rd_e;
   int       total = 0;
   int       bad = 0;
   int       done_cnt = 0;
   int       start_cnt = 0;
   logic     rd_issue = 1'b0;
   logic     rd_out_vld = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm);
      total++;
      bad++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // One cycle of read/write stimulus; c1/c2 queue the read result expected after this edge.
   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic en, input logic [4:0] r1, input logic [4:0] r2,
                        input logic c1, input logic [31:0] e1, input logic c2, input logic [31:0] e2);
      i_RegWrite        = we;
      i_write_register  = wa;
      i_write_data      = wd;
      i_enable          = en;
      i_read_register_1 = r1;
      i_read_register_2 = r2;
      rd_issue          = c1 | c2;
      if (c1 | c2) rd_q.push_back('{c1, e1, c2, e2});
      step();
      i_RegWrite = 1'b0;
      i_enable   = 1'b0;
      rd_issue   = 1'b0;
   endtask

   always @(posedge i_clk) rd_out_vld <= rd_issue;

   always @(negedge i_clk) begin
      if (i_rst === 1'b1) begin
         if (rd_out_vld) begin
            if (rd_q.size() == 0) fail("rd_q_underflow");
            else begin
               rd_e = rd_q.pop_front();
               if (rd_e.c1) chk("rd_data_1", o_read_data_1, rd_e.e1);
               if (rd_e.c2) chk("rd_data_2", o_read_data_2, rd_e.e2);
            end
         end
         if (o_dump_valid) begin
            chk("dump_busy", {31'd0, o_dump_busy}, 32'd1);
            if (dq.size() == 0) fail("dump_extra_word");
            else begin
               chk("dump_addr", {27'd0, o_dump_addr}, {27'd0, dq[0].a});
               chk("dump_data", o_dump_data, dq[0].d);
               if (i_dump_ready) void'(dq.pop_front());
            end
         end
         if (o_dump_done) begin
            done_cnt++;
            chk("done_busy", {31'd0, o_dump_busy}, 32'd0);
            chk("done_valid", {31'd0, o_dump_valid}, 32'd0);
         end
      end
   end

   task automatic chk_all_zero(input string nm);
      chk({nm, "_rd1"}, o_read_data_1, 32'd0);
      chk({nm, "_rd2"}, o_read_data_2, 32'd0);
      chk({nm, "_valid"}, {31'd0, o_dump_valid}, 32'd0);
      chk({nm, "_busy"}, {31'd0, o_dump_busy}, 32'd0);
      chk({nm, "_done"}, {31'd0, o_dump_done}, 32'd0);
      chk({nm, "_addr"}, {27'd0, o_dump_addr}, 32'd0);
      chk({nm, "_data"}, o_dump_data, 32'd0);
   endtask

   initial begin
      i_rst = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      chk_all_zero("reset");
      i_rst = 1'b1;
      step();

      // Write then read, same-cycle bypass, zero register.
      drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 5'd0, 0, 0, 0, 0);
      drive(0, 5'd0, 32'h0, 1, 5'd5, 5'd0, 1, 32'hDEADBEEF, 1, 32'h0);
      drive(1, 5'd7, 32'h12345678, 1, 5'd5, 5'd7, 1, 32'hDEADBEEF, 1, 32'h12345678);
      drive(1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd7, 1, 32'h0, 1, 32'h12345678);
      drive(0, 5'd0, 32'h0, 1, 5'd0, 5'd0, 1, 32'h0, 1, 32'h0);

      // Enable low holds the read outputs while reg3 changes.
      drive(1, 5'd3, 32'h111, 1, 5'd3, 5'd0, 1, 32'h111, 0, 0);
      drive(1, 5'd3, 32'h222, 0, 5'd3, 5'd0, 1, 32'h111, 0, 0);
      drive(0, 5'd0, 32'h0, 0, 5'd3, 5'd0, 1, 32'h111, 0, 0);
      drive(0, 5'd0, 32'h0, 1, 5'd3, 5'd0, 1, 32'h222, 0, 0);

      for (int k = 0; k < 32; k++) drive(1, 5'(k), 32'(100 + k), 0, 5'd0, 5'd0, 0, 0, 0, 0);

      // Dump with ready toggling; reg1 rewritten after it is latched, reg31 before.
      for (int k = 0; k < 32; k++)
         dq.push_back('{5'(k), (k == 0) ? 32'd0 : (k == 31) ? 32'h5555 : 32'(100 + k)});
      start_cnt    = done_cnt;
      i_dump_start = 1'b1;
      step();
      i_dump_start = 1'b0;
      for (int j = 0; j < 300 && done_cnt == start_cnt; j++) begin
         i_dump_ready = (j % 2 == 0);
         if (j == 4) begin
            i_RegWrite = 1'b1; i_write_register = 5'd1; i_write_data = 32'h7777;
         end
         if (j == 5) begin
            i_RegWrite = 1'b1; i_write_register = 5'd31; i_write_data = 32'h5555;
         end
         if (j == 6) begin
            i_enable = 1'b1; i_read_register_1 = 5'd31; rd_issue = 1'b1;
            rd_q.push_back('{1'b1, 32'h5555, 1'b0, 32'h0});
         end
         i_dump_start = (j == 8);
         step();
         i_RegWrite = 1'b0; i_enable = 1'b0; rd_issue = 1'b0; i_dump_start = 1'b0;
      end
      i_dump_ready = 1'b0;
      if (done_cnt == start_cnt) fail("dump1_timeout");
      repeat (3) step();
      chk("dump1_done_count", 32'(done_cnt), 32'(start_cnt + 1));
      chk("dump1_words_left", 32'(dq.size()), 32'd0);

      // Reset in the middle of a dump at index 10.
      for (int k = 0; k < 10; k++)
         dq.push_back('{5'(k), (k == 0) ? 32'd0 : (k == 1) ? 32'h7777 : 32'(100 + k)});
      start_cnt    = done_cnt;
      i_dump_start = 1'b1;
      i_dump_ready = 1'b1;
      step();
      i_dump_start = 1'b0;
      repeat (10) step();
      #2;
      i_rst = 1'b0;
      #1;
      chk_all_zero("abort");
      chk("abort_words_left", 32'(dq.size()), 32'd0);
      i_dump_ready = 1'b0;
      step();
      step();
      i_rst = 1'b1;
      repeat (3) step();
      chk("abort_no_done", 32'(done_cnt), 32'(start_cnt));

      // Fresh dump after reset: registers cleared, starts at addr 0.
      for (int k = 0; k < 32; k++) dq.push_back('{5'(k), 32'd0});
      start_cnt    = done_cnt;
      i_dump_start = 1'b1;
      i_dump_ready = 1'b1;
      step();
      i_dump_start = 1'b0;
      for (int j = 0; j < 100 && done_cnt == start_cnt; j++) step();
      i_dump_ready = 1'b0;
      if (done_cnt == start_cnt) fail("dump3_timeout");
      repeat (3) step();
      chk("dump3_done_count", 32'(done_cnt), 32'(start_cnt + 1));
      chk("dump3_words_left", 32'(dq.size()), 32'd0);
      chk("rd_q_left", 32'(rd_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 The block SHALL have parameter LEN, default 32, data width in bits.
REQ-002 The block SHALL have parameter NB_REG, default 32, number of registers.
REQ-003 The block SHALL have parameter NB_ADDR, default 5, address width, with NB_REG <= 2**NB_ADDR.
REQ-004 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads as 0 and ignores writes.
REQ-005 The block SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port i_rst  input  1  asynchronous active-low reset.
REQ-007 The block SHALL have port i_enable  input  1  pipeline enable for the read ports.
REQ-008 The block SHALL have port i_RegWrite  input  1  write strobe.
REQ-009 The block SHALL have ports i_read_register_1 and i_read_register_2  input  NB_ADDR  read addresses.
REQ-010 The block SHALL have port i_write_register  input  NB_ADDR  write address.
REQ-011 The block SHALL have port i_write_data  input  LEN  write data.
REQ-012 The block SHALL have ports o_read_data_1 and o_read_data_2  output  LEN  registered read data.
REQ-013 The block SHALL have port i_dump_start  input  1  request a full register dump.
REQ-014 The block SHALL have port i_dump_ready  input  1  consumer accepts the dump word.
REQ-015 The block SHALL have port o_dump_valid  output  1  dump word is valid.
REQ-016 The block SHALL have ports o_dump_addr (NB_ADDR) and o_dump_data (LEN)  output  index and value of the dump word.
REQ-017 The block SHALL have ports o_dump_busy and o_dump_done  output  1  dump in progress and one-cycle completion pulse.

Function
REQ-018 A write SHALL occur at the rising edge when i_RegWrite=1, independent of i_enable; addresses >= NB_REG SHALL be ignored.
REQ-019 When ZERO_REG=1, writes to address 0 SHALL be ignored, and reads of address 0 SHALL return 0.
REQ-020 When i_enable=1, each o_read_data_n SHALL load register[i_read_register_n] at the rising edge, giving 1-cycle latency; when i_enable=0, it SHALL hold its value.
REQ-021 Bypass: if i_RegWrite=1 and i_write_register equals a read address in the same cycle (and the write is not suppressed by REQ-018/REQ-019), that port SHALL load i_write_data instead of the stored value.
REQ-022 Reads of addresses >= NB_REG SHALL return 0.
REQ-023 The dump FSM SHALL have three states: IDLE, DUMP and DONE.
REQ-024 In IDLE, i_dump_start=1 SHALL move the FSM to DUMP with index=0, and SHALL latch o_dump_data=register[0] and o_dump_addr=0.
REQ-025 In DUMP, o_dump_valid and o_dump_busy SHALL be 1, and o_dump_data/o_dump_addr SHALL stay stable while i_dump_ready=0.
REQ-026 In DUMP, a transfer (o_dump_valid & i_dump_ready) at index < NB_REG-1 SHALL increment the index and latch the next register's stored value (no bypass) in the same edge.
REQ-027 A transfer at index NB_REG-1 SHALL move the FSM to DONE.
REQ-028 DONE SHALL assert o_dump_done=1 for exactly one cycle, with o_dump_valid=0 and o_dump_busy=0, then return to IDLE.
REQ-029 i_dump_start SHALL be ignored outside IDLE.
REQ-030 A write during a dump SHALL be visible to any register not yet latched; a word already latched SHALL NOT change.
REQ-031 Read ports and writes SHALL operate normally during a dump, with no stalls.

Reset
REQ-032 While i_rst=0, asynchronously: all registers=0, o_read_data_1/2=0, FSM=IDLE, index=0, o_dump_valid/busy/done=0, o_dump_addr=0, o_dump_data=0.
REQ-033 Reset asserted mid-dump SHALL abort the dump with no o_dump_done pulse.

Verification
REQ-034 Write reg5=0xDEADBEEF, next cycle read port1 addr 5 with i_enable=1 -> o_read_data_1=0xDEADBEEF one edge later.
REQ-035 Same cycle: write reg7=0x12345678 and read port2 addr 7 -> o_read_data_2=0x12345678 after one edge (bypass); also write reg0=0xFFFFFFFF and read addr 0 -> 0.
REQ-036 i_enable=0 while reg3 changes -> o_read_data_1 holds the old value until i_enable returns to 1.
REQ-037 Registers preloaded k -> 100+k, pulse start, ready toggling 1/0 -> 32 transfers, addr 0..31, data 0,101..131 (reg0=0), stable during stalls, done pulses once, busy falls with done.
REQ-038 Dump at index 10, deassert i_rst -> all outputs 0 immediately, no done pulse; new start after reset -> dump begins at addr 0 with data 0.
